pcihellocore_hexport_arbiter: RTL and testbench
===============================================

# pcihellocore_hexport_arbiter

Round-robin write arbiter sharing the single 32-bit hex display PIO (Avalon-MM slave, register at address 0, no waitrequest) among NUM_REQ internal requesters. Each requester posts a value with a valid/ack handshake. The arbiter sequences exactly one single-cycle Avalon write per grant, then enforces a minimum display hold time before the next grant so every value stays visible. It sits between the requester logic and the PIO's s1 slave in the pcihellocore fabric.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, write data width; matches PIO register width
- HOLD_CYCLES, 16, minimum cycles between consecutive writes after the write cycle (0 allowed)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a value pending
- req_data  in  NUM_REQ*DATA_W  value of requester i in bits [i*DATA_W +: DATA_W]
- req_ack  out  NUM_REQ  one-cycle pulse: requester i's value is being written this cycle
- address  out  2  Avalon address to PIO; constant 0
- chipselect  out  1  Avalon chipselect
- write_n  out  1  Avalon write strobe, active low
- writedata  out  DATA_W  Avalon write data
- last_owner  out  clog2(NUM_REQ)  index of the most recently granted requester
- last_value  out  DATA_W  shadow of the last value written to the PIO
- busy  out  1  high in WRITE and HOLD states

## Operation
- One clock and one reset, as decided above: clk, reset synchronous active-high.
- FSM states are IDLE, WRITE and HOLD.
- IDLE: if any req_valid bit is set, select the winner by round-robin. The search starts at index (last_owner+1) mod NUM_REQ and wraps. Latch the winner's req_data into writedata and its index into a grant register, then go to WRITE. With no request, stay in IDLE.
- WRITE, exactly one cycle:
  - chipselect=1, write_n=0, address=0, writedata=latched value.
  - req_ack[grant]=1, all other ack bits 0.
  - last_owner<=grant, last_value<=writedata.
  - Next state is HOLD if HOLD_CYCLES>0, else IDLE.
- HOLD: the counter loads HOLD_CYCLES-1 on entry and decrements each cycle. Exit to IDLE in the cycle the count reads 0. Requests are ignored in HOLD.
- Data is captured at grant. If a requester drops req_valid between grant and WRITE, the write still completes and ack still pulses.
- After its ack, a requester that keeps req_valid high is treated as a new request. Round-robin then places it last behind any other pending requesters.
- Outside WRITE: chipselect=0, write_n=1, address=0, req_ack=0.
- The arbiter never reads the PIO, so there is no read path.
- Reset values: state=IDLE, chipselect=0, write_n=1, address=0, writedata=0, req_ack=0, busy=0, last_value=0, last_owner=NUM_REQ-1. With last_owner at NUM_REQ-1, requester 0 wins first after reset.
- Reset asserted in any state returns to IDLE on the next edge. Any pending WRITE is abandoned: no strobe and no ack.

## Timing
- Request-to-write latency: req_valid sampled high in IDLE at edge N makes WRITE active in cycle N+1. The PIO register updates at edge N+2.
- Ack coincides with the write strobe cycle.
- Back-to-back writes are separated by exactly 1+HOLD_CYCLES+1 cycles when requests are continuously pending: WRITE, HOLD×HOLD_CYCLES, IDLE, then the next WRITE.
  - HOLD_CYCLES=0 gives a write every 2 cycles.
- busy rises in the WRITE cycle and falls when the FSM enters IDLE.
- All outputs are registered. There are no combinational paths from req_* to Avalon outputs.

## Test plan
- Reset then single request: req_valid=4'b0100, req_data[2]=32'hDEADBEEF → in the cycle after sampling: chipselect=1, write_n=0, writedata=32'hDEADBEEF, req_ack=4'b0100. Then last_owner=2, last_value=32'hDEADBEEF, busy high for 17 cycles.
- All four requesters continuously valid, HOLD_CYCLES=16 → grants in order 0,1,2,3,0; writes exactly 18 cycles apart; ack is one-cycle per grant.
- Requester 1 asserts at the same edge the FSM enters HOLD after granting 3 → request waits. Next grant is 0 if 0 is pending, else 1, only after the HOLD count expires.
- Grant requester 0, then drop req_valid[0] before WRITE → write with the latched data still occurs and req_ack[0] still pulses.
- Assert reset during HOLD and during a pending grant → next cycle state is IDLE, chipselect=0, write_n=1, last_value=0. The first post-reset grant goes to the lowest-index valid requester.
- HOLD_CYCLES=0 with two requesters pending → alternating writes every 2 cycles; no strobe is held for more than 1 cycle.

Source files
------------

// File: rtl/pcihellocore_hexport_arbiter.sv
// pcihellocore_hexport_arbiter: round-robin arbiter sharing the hex display PIO among NUM_REQ requesters
//   clk, reset             : system clock, synchronous active-high reset
//   req_valid, req_data    : per-requester pending flag and value (requester i at [i*DATA_W +: DATA_W])
//   req_ack                : one-cycle pulse while requester i's value is being written
//   address, chipselect,
//   write_n, writedata     : Avalon-MM write to the PIO s1 register (address 0)
//   last_owner, last_value : most recently granted requester and the value it wrote
//   busy                   : high during WRITE and HOLD
module pcihellocore_hexport_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 32,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [1:0]                 address,
    output logic                       chipselect,
    output logic                       write_n,
    output logic [DATA_W-1:0]          writedata,
    output logic [$clog2(NUM_REQ)-1:0] last_owner,
    output logic [DATA_W-1:0]          last_value,
    output logic                       busy
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;
    state_t state, state_next;
    logic [OW-1:0] grant, win;
    logic [HW-1:0] hold_cnt;
    logic [DATA_W-1:0] data_arr [NUM_REQ];
    assign address = 2'b00;
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_data
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
    // Scan from the farthest to the nearest slot after last_owner so the nearest valid one wins;
    // last_owner itself is visited first and therefore ranks last.
    always_comb begin
        win = last_owner;
        for (int k = NUM_REQ; k >= 1; k--)
            if (req_valid[OW'((int'(last_owner) + k) % NUM_REQ)]) win = OW'((int'(last_owner) + k) % NUM_REQ);
    end
    always_comb begin
        state_next = state == IDLE  ? (|req_valid ? WRITE : IDLE) :
                     state == WRITE ? (HOLD_CYCLES > 0 ? HOLD : IDLE) :
                                      (hold_cnt == '0 ? IDLE : HOLD);
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end
    // Avalon strobes and ack are registered from state_next so they line up exactly with the WRITE state.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant      <= '0;
            writedata  <= '0;
            last_owner <= OW'(NUM_REQ - 1);
            last_value <= '0;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            req_ack    <= '0;
            busy       <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            chipselect <= state_next == WRITE;
            write_n    <= state_next != WRITE;
            req_ack    <= state_next == WRITE ? (NUM_REQ'(1) << win) : '0;
            busy       <= state_next != IDLE;
            hold_cnt   <= state == WRITE ? HW'(HOLD_CYCLES - 1) : state == HOLD ? hold_cnt - 1'b1 : hold_cnt;
            if (state == IDLE && |req_valid) begin
                grant     <= win;
                writedata <= data_arr[win];
            end
            if (state == WRITE) begin
                last_owner <= grant;
                last_value <= writedata;
            end
        end
    end
endmodule

// File: tb/tb_pcihellocore_hexport_arbiter.sv
// tb_pcihellocore_hexport_arbiter: randomized scoreboard bench for two arbiter configurations
module tb_pcihellocore_hexport_arbiter;
    typedef struct { int cyc; int owner; logic [31:0] data; } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] rv = '0;
    logic [127:0] rd = '0;
    logic [3:0] ack0;
    logic [1:0] addr0, lo0;
    logic cs0, wn0, busy0;
    logic [31:0] wd0, lv0;
    logic [1:0] ack1, addr1;
    logic [0:0] lo1;
    logic cs1, wn1, busy1;
    logic [31:0] wd1, lv1;
    exp_t q0[$], q1[$];
    int cyc = 0, errors = 0, checks = 0;
    int last_m[2], free_m[2], vis_lo[2], pend_o[2];
    logic [31:0] vis_lv[2], pend_d[2];
    logic pend_v[2];
    logic rst_seen = 1'b0;

    pcihellocore_hexport_arbiter #(.NUM_REQ(4), .DATA_W(32), .HOLD_CYCLES(16)) dut0 (
        .clk(clk), .reset(reset), .req_valid(rv), .req_data(rd), .req_ack(ack0),
        .address(addr0), .chipselect(cs0), .write_n(wn0), .writedata(wd0),
        .last_owner(lo0), .last_value(lv0), .busy(busy0));

    pcihellocore_hexport_arbiter #(.NUM_REQ(2), .DATA_W(32), .HOLD_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset), .req_valid(rv[1:0]), .req_data(rd[63:0]), .req_ack(ack1),
        .address(addr1), .chipselect(cs1), .write_n(wn1), .writedata(wd1),
        .last_owner(lo1), .last_value(lv1), .busy(busy1));

    initial forever #5 clk = ~clk;

    function automatic logic [127:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference: a requester may be granted once the arbiter is free; the grant goes to the first
    // valid index after the previous owner, its write shows in the following cycle, and the
    // arbiter is free again 2+HOLD cycles after the grant.
    task automatic model(input int di, input logic r, input logic [3:0] v, input logic [127:0] d);
        int n, h, w;
        n = di == 0 ? 4 : 2;
        h = di == 0 ? 16 : 0;
        if (r) begin
            last_m[di] = n - 1; free_m[di] = cyc + 1;
            vis_lo[di] = n - 1; vis_lv[di] = '0; pend_v[di] = 1'b0;
            return;
        end
        if (pend_v[di]) begin
            vis_lo[di] = pend_o[di]; vis_lv[di] = pend_d[di]; pend_v[di] = 1'b0;
        end
        if (cyc < free_m[di] || v == '0) return;
        w = 0;
        for (int k = n; k >= 1; k--)
            if (v[2'((last_m[di] + k) % n)]) w = (last_m[di] + k) % n;
        pend_o[di] = w;
        pend_d[di] = 32'(d >> (w * 32));
        pend_v[di] = 1'b1;
        last_m[di] = w;
        free_m[di] = cyc + h + 2;
        if (di == 0) q0.push_back('{cyc, w, pend_d[di]});
        else q1.push_back('{cyc, w, pend_d[di]});
    endtask

    task automatic step(input logic r, input logic [3:0] v, input logic [127:0] d);
        @(negedge clk);
        reset = r; rv = v; rd = d;
        @(posedge clk);
        cyc++;
        rst_seen = r;
        model(0, r, v, d);
        model(1, r, {2'b00, v[1:0]}, d);
    endtask

    task automatic mon(input int d, input logic cs, input logic wn, input logic [3:0] ack,
                       input logic [1:0] addr, input logic [31:0] wd, input int lo,
                       input logic [31:0] lv, input logic busy);
        exp_t e;
        logic due;
        if (d == 0) due = q0.size() > 0 && q0[0].cyc == cyc;
        else due = q1.size() > 0 && q1[0].cyc == cyc;
        chk($sformatf("d%0d_cs_wn", d), {62'd0, cs, wn}, {62'd0, due, !due});
        if (due) begin
            if (d == 0) e = q0.pop_front();
            else e = q1.pop_front();
            chk($sformatf("d%0d_writedata", d), wd, e.data);
            chk($sformatf("d%0d_ack", d), ack, 4'd1 << e.owner);
        end else
            chk($sformatf("d%0d_ack_idle", d), ack, 0);
        chk($sformatf("d%0d_address", d), addr, 0);
        chk($sformatf("d%0d_last_owner", d), lo, vis_lo[d]);
        chk($sformatf("d%0d_last_value", d), lv, vis_lv[d]);
        chk($sformatf("d%0d_busy", d), busy, cyc < free_m[d] - 1);
        if (rst_seen) chk($sformatf("d%0d_writedata_rst", d), wd, 0);
    endtask

    initial forever begin
        @(negedge clk);
        if (cyc > 0) begin
            mon(0, cs0, wn0, ack0, addr0, wd0, int'(lo0), lv0, busy0);
            mon(1, cs1, wn1, {2'b00, ack1}, addr1, wd1, int'(lo1), lv1, busy1);
        end
    end

    initial begin
        logic [127:0] d;
        repeat (3) step(1'b1, 4'b0000, rnd());
        d = rnd();
        d[95:64] = 32'hDEADBEEF;
        step(1'b0, 4'b0100, d);
        repeat (24) step(1'b0, 4'b0000, rnd());
        for (int i = 0; i < 100; i++) step(1'b0, 4'b1111, rnd());
        repeat (20) step(1'b0, 4'b0000, rnd());
        step(1'b0, 4'b1000, rnd());
        repeat (22) step(1'b0, 4'b0010, rnd());
        step(1'b0, 4'b1001, rnd());
        repeat (20) step(1'b0, 4'b0011, rnd());
        step(1'b0, 4'b0001, rnd());
        repeat (20) step(1'b0, 4'b0000, rnd());
        step(1'b0, 4'b0001, rnd());
        repeat (5) step(1'b0, 4'b0000, rnd());
        step(1'b1, 4'b0000, rnd());
        step(1'b0, 4'b0110, rnd());
        repeat (20) step(1'b0, 4'b0000, rnd());
        step(1'b0, 4'b0001, rnd());
        step(1'b1, 4'b0001, rnd());
        step(1'b1, 4'b0100, rnd());
        step(1'b0, 4'b1100, rnd());
        repeat (20) step(1'b0, 4'b0000, rnd());
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 60) == 0, 4'($urandom_range(0, 15)), rnd());
        repeat (25) step(1'b0, 4'b0000, rnd());
        @(posedge clk);
        chk("queue_drained", 64'(q0.size() + q1.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
